// File: rtl/spi_fib_packet_tx_if.sv
// SPI-side byte input and FIB-side packet stream of the SPI->FIB packet transmitter.
interface spi_fib_packet_tx_if;
    logic       spi_rx_valid;
    logic [7:0] spi_rx_byte;
    logic       spi_rx_abort;
    logic       fib_ready;
    logic       RX_valid;
    logic [7:0] data_SPI_to_FIB;
    logic       pkt_dropped;
    logic       pkt_pending;

    modport slave (
        input  spi_rx_valid, spi_rx_byte, spi_rx_abort, fib_ready,
        output RX_valid, data_SPI_to_FIB, pkt_dropped, pkt_pending
    );

    modport master (
        output spi_rx_valid, spi_rx_byte, spi_rx_abort, fib_ready,
        input  RX_valid, data_SPI_to_FIB, pkt_dropped, pkt_pending
    );
endinterface

// File: rtl/spi_fib_packet_tx.sv
// Buffers whole NDN packets from the SPI byte receiver and replays each one to the FIB
// as a start strobe followed by an unbroken byte stream.
module spi_fib_packet_tx #(
    parameter int unsigned DEPTH        = 128,
    parameter int unsigned PTR_W        = 7,
    parameter int unsigned PREFIX_BYTES = 8,
    parameter int unsigned DATA_BYTES   = 32
) (
    input logic               clk,
    input logic               rst,
    spi_fib_packet_tx_if.slave bus
);
    localparam int unsigned AW       = PTR_W + 1;
    localparam int unsigned INT_LEN  = 1 + PREFIX_BYTES;
    localparam int unsigned DATA_LEN = INT_LEN + DATA_BYTES;
    localparam int unsigned LEN_W    = $clog2(DATA_LEN + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_FILL, RX_DROP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_SEND} tx_state_t;

    rx_state_t        rx_state;
    tx_state_t        tx_state;
    logic [7:0]       mem [DEPTH];
    logic [AW-1:0]    wr_ptr, commit_ptr, rd_ptr;
    logic [PTR_W-1:0] pkt_count, cnt_next;
    logic [LEN_W-1:0] rx_left, tx_left;
    logic [LEN_W-1:0] meta_len_c, head_len_c;
    logic [AW-1:0]    free_c;
    logic             wr_en_c, commit_c, done_c;

    function automatic logic [LEN_W-1:0] pkt_len(input logic is_data);
        return is_data ? LEN_W'(DATA_LEN) : LEN_W'(INT_LEN);
    endfunction

    // Space check, FIFO write enable and packet-count bookkeeping
    always_comb begin
        meta_len_c = pkt_len(bus.spi_rx_byte[7]);
        head_len_c = pkt_len(mem[rd_ptr[PTR_W-1:0]][7]);
        free_c     = AW'(DEPTH) - (wr_ptr - rd_ptr);
        wr_en_c    = 1'b0;
        commit_c   = 1'b0;
        case (rx_state)
            RX_IDLE: wr_en_c = bus.spi_rx_valid && (free_c >= AW'(meta_len_c));
            RX_FILL: begin
                wr_en_c  = bus.spi_rx_valid && !bus.spi_rx_abort;
                commit_c = wr_en_c && (rx_left == LEN_W'(1));
            end
            default: ;
        endcase
        done_c   = (tx_state == TX_SEND) && (tx_left == '0);
        cnt_next = pkt_count + PTR_W'(commit_c) - PTR_W'(done_c);
    end

    always_ff @(posedge clk) begin
        if (wr_en_c && !rst) mem[wr_ptr[PTR_W-1:0]] <= bus.spi_rx_byte;
    end

    // RX: admit, fill, drop or abort packets coming from SPI
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state        <= RX_IDLE;
            wr_ptr          <= '0;
            commit_ptr      <= '0;
            rx_left         <= '0;
            bus.pkt_dropped <= 1'b0;
        end else begin
            bus.pkt_dropped <= 1'b0;
            case (rx_state)
                RX_IDLE: if (bus.spi_rx_valid) begin
                    rx_left <= meta_len_c - LEN_W'(1);
                    if (wr_en_c) begin
                        wr_ptr   <= wr_ptr + AW'(1);
                        rx_state <= RX_FILL;
                    end else begin
                        bus.pkt_dropped <= 1'b1;
                        rx_state        <= RX_DROP;
                    end
                end
                RX_FILL: if (bus.spi_rx_abort) begin
                    wr_ptr          <= commit_ptr;
                    bus.pkt_dropped <= 1'b1;
                    rx_state        <= RX_IDLE;
                end else if (bus.spi_rx_valid) begin
                    wr_ptr  <= wr_ptr + AW'(1);
                    rx_left <= rx_left - LEN_W'(1);
                    if (commit_c) begin
                        commit_ptr <= wr_ptr + AW'(1);
                        rx_state   <= RX_IDLE;
                    end
                end
                RX_DROP: if (bus.spi_rx_abort) begin
                    wr_ptr   <= commit_ptr;
                    rx_state <= RX_IDLE;
                end else if (bus.spi_rx_valid) begin
                    rx_left <= rx_left - LEN_W'(1);
                    if (rx_left == LEN_W'(1)) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // TX: strobe, then stream the head packet one byte per clock
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state            <= TX_IDLE;
            rd_ptr              <= '0;
            tx_left             <= '0;
            pkt_count           <= '0;
            bus.pkt_pending     <= 1'b0;
            bus.RX_valid        <= 1'b0;
            bus.data_SPI_to_FIB <= '0;
        end else begin
            pkt_count       <= cnt_next;
            bus.pkt_pending <= (cnt_next != '0);
            bus.RX_valid    <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    bus.data_SPI_to_FIB <= '0;
                    if ((pkt_count != '0) && bus.fib_ready) begin
                        bus.RX_valid <= 1'b1;
                        tx_state     <= TX_START;
                    end
                end
                TX_START: begin
                    bus.data_SPI_to_FIB <= mem[rd_ptr[PTR_W-1:0]];
                    rd_ptr              <= rd_ptr + AW'(1);
                    tx_left             <= head_len_c - LEN_W'(1);
                    tx_state            <= TX_SEND;
                end
                TX_SEND: if (tx_left == '0) begin
                    bus.data_SPI_to_FIB <= '0;
                    tx_state            <= TX_IDLE;
                end else begin
                    bus.data_SPI_to_FIB <= mem[rd_ptr[PTR_W-1:0]];
                    rd_ptr              <= rd_ptr + AW'(1);
                    tx_left             <= tx_left - LEN_W'(1);
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_fib_packet_tx.sv
// Directed and randomized bench for spi_fib_packet_tx, checked against a packet-level
// queue model of FIFO occupancy and replay order.
module tb_spi_fib_packet_tx;
    localparam int DEPTH = 128;

    typedef logic [7:0] byte_q_t [$];

    logic clk;
    logic rst;
    spi_fib_packet_tx_if bus();

    spi_fib_packet_tx dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: bytes and lengths of packets accepted but not yet replayed, in order
    logic [7:0] exp_bytes [$];
    int         exp_lens  [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic int model_used();
        int s = 0;
        foreach (exp_lens[i]) s += exp_lens[i];
        return s;
    endfunction

    function automatic byte_q_t rand_pkt(input bit is_data);
        byte_q_t p;
        p.push_back({is_data, 7'($urandom)});
        for (int i = 1; i < (is_data ? 41 : 9); i++) p.push_back(8'($urandom));
        return p;
    endfunction

    // Drives a packet from SPI; abort_at >= 0 raises abort (with a competing valid byte) after that many bytes
    task automatic send_pkt(input byte_q_t p, input int abort_at);
        int len = p.size();
        bit accept = (DEPTH - model_used()) >= len;
        for (int i = 0; i < len; i++) begin
            if (i == abort_at) begin
                bus.spi_rx_valid = 1'b1;
                bus.spi_rx_byte  = 8'($urandom);
                bus.spi_rx_abort = 1'b1;
                @(posedge clk); #1;
                check("abort_drop", 32'(bus.pkt_dropped), 32'(accept));
                bus.spi_rx_abort = 1'b0;
                bus.spi_rx_valid = 1'b0;
                return;
            end
            bus.spi_rx_valid = 1'b1;
            bus.spi_rx_byte  = p[i];
            @(posedge clk); #1;
            if (i == 0) check("meta_drop", 32'(bus.pkt_dropped), 32'(!accept));
        end
        bus.spi_rx_valid = 1'b0;
        if (accept) begin
            foreach (p[i]) exp_bytes.push_back(p[i]);
            exp_lens.push_back(len);
        end
    endtask

    // Waits for the next strobe and checks the whole replayed packet against the model head
    task automatic recv_pkt();
        int  len;
        bit  seen = 1'b0;
        logic [7:0] exp_b;
        len = exp_lens.pop_front();
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk);
            seen = bus.RX_valid;
        end
        check("rx_valid_timeout", 32'(seen), 32'd1);
        if (!seen) begin
            for (int i = 0; i < len; i++) void'(exp_bytes.pop_front());
            @(posedge clk); #1;
            return;
        end
        check("start_data", 32'(bus.data_SPI_to_FIB), 32'd0);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            exp_b = exp_bytes.pop_front();
            check($sformatf("byte%0d", i + 1), 32'(bus.data_SPI_to_FIB), 32'(exp_b));
            check("strobe_in_body", 32'(bus.RX_valid), 32'd0);
        end
        @(negedge clk);
        check("tail_data", 32'(bus.data_SPI_to_FIB), 32'd0);
        check("tail_gap", 32'(bus.RX_valid), 32'd0);
        check("tail_pending", 32'(bus.pkt_pending), 32'(exp_lens.size() != 0));
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t p;
        bit seen;

        bus.spi_rx_valid = 1'b0;
        bus.spi_rx_byte  = '0;
        bus.spi_rx_abort = 1'b0;
        bus.fib_ready    = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_valid", 32'(bus.RX_valid), 32'd0);
        check("rst_data", 32'(bus.data_SPI_to_FIB), 32'd0);
        check("rst_dropped", 32'(bus.pkt_dropped), 32'd0);
        check("rst_pending", 32'(bus.pkt_pending), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Interest 08,01..08 replayed immediately
        bus.fib_ready = 1'b1;
        p = {};
        p.push_back(8'h08);
        for (int i = 1; i <= 8; i++) p.push_back(8'(i));
        send_pkt(p, -1);
        recv_pkt();

        // Data packet with payload 0x00..0x1F
        p = {};
        p.push_back(8'h88);
        for (int i = 0; i < 8; i++)  p.push_back(8'(8'hA0 + i));
        for (int i = 0; i < 32; i++) p.push_back(8'(i));
        send_pkt(p, -1);
        recv_pkt();

        // Hold FIB busy: nothing leaves while packets queue up
        bus.fib_ready = 1'b0;
        send_pkt(rand_pkt(1'b1), -1);
        send_pkt(rand_pkt(1'b1), -1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("held_no_strobe", 32'(bus.RX_valid), 32'd0);
        end
        check("held_pending", 32'(bus.pkt_pending), 32'd1);
        @(posedge clk); #1;
        // Fill to 118 bytes, then a data packet no longer fits but an interest still does
        for (int k = 0; k < 4; k++) send_pkt(rand_pkt(1'b0), -1);
        send_pkt(rand_pkt(1'b1), -1);
        send_pkt(rand_pkt(1'b0), -1);
        send_pkt(rand_pkt(1'b0), -1);
        bus.fib_ready = 1'b1;
        while (exp_lens.size() != 0) recv_pkt();

        // Abort after 5 interest bytes, then an intact interest
        send_pkt(rand_pkt(1'b0), 5);
        send_pkt(rand_pkt(1'b0), -1);
        recv_pkt();

        // Reset in the middle of a replay
        send_pkt(rand_pkt(1'b1), -1);
        seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk);
            seen = bus.RX_valid;
        end
        check("rst_mid_strobe", 32'(seen), 32'd1);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_rx_valid", 32'(bus.RX_valid), 32'd0);
        check("mid_rst_data", 32'(bus.data_SPI_to_FIB), 32'd0);
        check("mid_rst_dropped", 32'(bus.pkt_dropped), 32'd0);
        check("mid_rst_pending", 32'(bus.pkt_pending), 32'd0);
        rst = 1'b0;
        exp_bytes.delete();
        exp_lens.delete();
        @(posedge clk); #1;
        send_pkt(rand_pkt(1'b1), -1);
        recv_pkt();

        // Randomized rounds: queue with FIB held off, then drain
        for (int r = 0; r < 4; r++) begin
            bus.fib_ready = 1'b0;
            for (int k = 0; k < 6; k++) begin
                bit is_data = 1'($urandom);
                int ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, is_data ? 40 : 8) : -1;
                send_pkt(rand_pkt(is_data), ab);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #0;
            end
            @(negedge clk);
            check("rand_pending", 32'(bus.pkt_pending), 32'(exp_lens.size() != 0));
            @(posedge clk); #1;
            bus.fib_ready = 1'b1;
            while (exp_lens.size() != 0) recv_pkt();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
